// File: rtl/rc4_decryptor.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_decryptor
//  Purpose  : RC4 PRGA keystream engine. It walks an externally initialised
//             S-box held in a synchronous RAM, swaps S[i]/S[j] for each byte,
//             and writes ciphertext XOR keystream into a plaintext RAM.
//             Each message byte takes exactly six clock cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   sole clock, rising edge
//    reset            in   synchronous, active-high reset
//    start            in   level request to begin a decryption run
//    finished         out  high while the run is complete (DONE state)
//    s_ram_out        in   S RAM read data (one cycle after the address)
//    s_address        out  S RAM address
//    s_ram_in         out  S RAM write data
//    s_write_enable   out  S RAM write strobe
//    enc_rom_out      in   ciphertext ROM read data
//    enc_address      out  ciphertext ROM address (always the byte index k)
//    dec_ram_in       out  plaintext RAM write data
//    dec_address      out  plaintext RAM address
//    dec_write_enable out  plaintext RAM write strobe
// ============================================================================
module rc4_decryptor #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int MSG_LEN        = 32,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  input  logic [DATA_WIDTH-1:0]     s_ram_out,
  output logic [ADDR_WIDTH-1:0]     s_address,
  output logic [DATA_WIDTH-1:0]     s_ram_in,
  output logic                      s_write_enable,
  input  logic [DATA_WIDTH-1:0]     enc_rom_out,
  output logic [MSG_ADDR_WIDTH-1:0] enc_address,
  output logic [DATA_WIDTH-1:0]     dec_ram_in,
  output logic [MSG_ADDR_WIDTH-1:0] dec_address,
  output logic                      dec_write_enable
);

  localparam logic [MSG_ADDR_WIDTH-1:0] LAST_K = MSG_ADDR_WIDTH'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    CAP_J = 3'd3,
    WR_J  = 3'd4,
    RD_F  = 3'd5,
    CAP_F = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     i_q, i_d;
  logic [ADDR_WIDTH-1:0]     j_q, j_d;
  logic [MSG_ADDR_WIDTH-1:0] k_q, k_d;
  logic [DATA_WIDTH-1:0]     si_q, si_d;
  logic [DATA_WIDTH-1:0]     sj_q, sj_d;
  logic [DATA_WIDTH-1:0]     enc_q, enc_d;

  // j + S[i] is needed in CAP_I both as the new j and as the read address,
  // because S[i] only arrives from the RAM in that same cycle.
  logic [ADDR_WIDTH-1:0] w_j_sum;
  logic [ADDR_WIDTH-1:0] w_f_addr;

  assign w_j_sum  = j_q + ADDR_WIDTH'(s_ram_out);
  assign w_f_addr = ADDR_WIDTH'(si_q) + ADDR_WIDTH'(sj_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      enc_q   <= enc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    i_d              = i_q;
    j_d              = j_q;
    k_d              = k_q;
    si_d             = si_q;
    sj_d             = sj_q;
    enc_d            = enc_q;
    finished         = 1'b0;
    s_address        = '0;
    s_ram_in         = '0;
    s_write_enable   = 1'b0;
    enc_address      = k_q;
    dec_ram_in       = '0;
    dec_address      = '0;
    dec_write_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = ADDR_WIDTH'(1);
          j_d     = '0;
          k_d     = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        s_address = i_q;
        state_d   = CAP_I;
      end
      CAP_I: begin
        si_d      = s_ram_out;
        enc_d     = enc_rom_out;
        j_d       = w_j_sum;
        s_address = w_j_sum;
        state_d   = CAP_J;
      end
      CAP_J: begin
        // S[j] is on the read bus now; forward it straight into the
        // write to S[i] while also capturing it for the output sum.
        sj_d           = s_ram_out;
        s_address      = i_q;
        s_ram_in       = s_ram_out;
        s_write_enable = 1'b1;
        state_d        = WR_J;
      end
      WR_J: begin
        s_address      = j_q;
        s_ram_in       = si_q;
        s_write_enable = 1'b1;
        state_d        = RD_F;
      end
      RD_F: begin
        s_address = w_f_addr;
        state_d   = CAP_F;
      end
      CAP_F: begin
        dec_address      = k_q;
        dec_ram_in       = s_ram_out ^ enc_q;
        dec_write_enable = 1'b1;
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          i_d     = i_q + 1'b1;
          state_d = RD_I;
        end
      end
      DONE: begin
        finished = 1'b1;
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_decryptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rc4_decryptor
//  Purpose  : Self-checking bench for rc4_decryptor. Models the S RAM,
//             ciphertext ROM and plaintext RAM, predicts plaintext with a
//             plain software RC4 PRGA, and checks writes from a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rc4_decryptor;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int ML  = 32;
  localparam int MAW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           finished;
  logic [DW-1:0]  s_ram_out;
  logic [AW-1:0]  s_address;
  logic [DW-1:0]  s_ram_in;
  logic           s_write_enable;
  logic [DW-1:0]  enc_rom_out;
  logic [MAW-1:0] enc_address;
  logic [DW-1:0]  dec_ram_in;
  logic [MAW-1:0] dec_address;
  logic           dec_write_enable;

  rc4_decryptor #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSG_LEN(ML), .MSG_ADDR_WIDTH(MAW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .finished(finished),
    .s_ram_out(s_ram_out), .s_address(s_address), .s_ram_in(s_ram_in),
    .s_write_enable(s_write_enable), .enc_rom_out(enc_rom_out),
    .enc_address(enc_address), .dec_ram_in(dec_ram_in),
    .dec_address(dec_address), .dec_write_enable(dec_write_enable)
  );

  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  logic [7:0] s_mem   [256];
  logic [7:0] enc_mem [ML];
  logic [7:0] dec_mem [ML];
  logic [7:0] init_s  [256];
  logic [7:0] init_enc[ML];
  logic       ld = 1'b0;
  int         cyc_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (ld) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= init_s[a];
      for (int a = 0; a < ML; a++) begin
        enc_mem[a] <= init_enc[a];
        dec_mem[a] <= 8'h00;
      end
    end else begin
      s_ram_out   <= s_mem[s_address];
      enc_rom_out <= enc_mem[enc_address];
      if (s_write_enable)   s_mem[s_address]     <= s_ram_in;
      if (dec_write_enable) dec_mem[dec_address] <= dec_ram_in;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain RC4 PRGA over its own copy of S.
  int         ref_s[256];
  logic [12:0] exp_q[$];

  task automatic model_run();
    int i = 0, j = 0, t;
    for (int k = 0; k < ML; k++) begin
      i = (i + 1) % 256;
      j = (j + ref_s[i]) % 256;
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
      t = ref_s[(ref_s[i] + ref_s[j]) % 256] ^ int'(init_enc[k]);
      exp_q.push_back({5'(k), 8'(t)});
    end
  endtask

  // Monitor: pops the scoreboard on every plaintext write.
  logic [12:0] mon_e;
  bit          log_en  = 1'b0;
  bit          snap_en = 1'b0;
  bit          snap_ok = 1'b0;
  logic [7:0]  snap[3];
  logic [15:0] swr_a[$];
  int          swr_t[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (s_write_enable && log_en && swr_a.size() < 2) begin
        swr_a.push_back({s_address, s_ram_in});
        swr_t.push_back(cyc_cnt);
      end
      if (dec_write_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dec_write", {dec_address, dec_ram_in}, 13'h1fff);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("dec[%0d]", mon_e[12:8]), {dec_address, dec_ram_in}, mon_e);
        end
        if (snap_en && dec_address == 5'd2) begin
          snap[0] = s_mem[2]; snap[1] = s_mem[3]; snap[2] = s_mem[5];
          snap_ok = 1'b1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic load_identity(input logic [7:0] encv);
    for (int a = 0; a < 256; a++) begin init_s[a] = 8'(a); ref_s[a] = a; end
    for (int a = 0; a < ML; a++) init_enc[a] = encv;
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic load_random();
    int r; logic [7:0] t;
    for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = init_s[a]; init_s[a] = init_s[r]; init_s[r] = t;
    end
    for (int a = 0; a < 256; a++) ref_s[a] = int'(init_s[a]);
    for (int a = 0; a < ML; a++) init_enc[a] = 8'($urandom);
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic do_run(input bit hold, output int cycles);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cycles = 0;
    while (!finished && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("run_reaches_done", finished, 1);
  endtask

  task automatic check_final(input string nm);
    int bad = 0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 256; a++) if (int'(s_mem[a]) != ref_s[a]) bad++;
    chk({nm, "_final_S_mismatches"}, bad, 0);
    chk({nm, "_scoreboard_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc, n, bad;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_finished",  finished, 0);
    chk("rst_s_we",      s_write_enable, 0);
    chk("rst_dec_we",    dec_write_enable, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_s_ram_in",  s_ram_in, 0);
    chk("rst_enc_addr",  enc_address, 0);
    chk("rst_dec_addr",  dec_address, 0);
    chk("rst_dec_data",  dec_ram_in, 0);
    @(negedge clk) reset = 1'b0;

    // Identity S, zero ciphertext.
    load_identity(8'h00);
    model_run();
    log_en = 1'b1; snap_en = 1'b1;
    do_run(1'b0, cyc);
    log_en = 1'b0; snap_en = 1'b0;
    chk("id0_swap_write_count", swr_a.size(), 2);
    if (swr_a.size() == 2) begin
      chk("id0_swap_write0", swr_a[0], 16'h0101);
      chk("id0_swap_write1", swr_a[1], 16'h0101);
      chk("id0_swap_consecutive", swr_t[1] - swr_t[0], 1);
    end
    chk("id0_snap_taken", snap_ok, 1);
    chk("id0_S2", snap[0], 8'h03);
    chk("id0_S3", snap[1], 8'h05);
    chk("id0_S5", snap[2], 8'h02);
    check_final("id0");
    chk("id0_dec0", dec_mem[0], 8'h02);
    chk("id0_dec1", dec_mem[1], 8'h05);
    chk("id0_dec2", dec_mem[2], 8'h07);

    // Identity S, 0xFF ciphertext, latency check.
    load_identity(8'hFF);
    model_run();
    do_run(1'b0, cyc);
    chk("idff_done_latency", cyc, 192);
    check_final("idff");
    chk("idff_dec0", dec_mem[0], 8'hFD);
    chk("idff_dec1", dec_mem[1], 8'hFA);
    chk("idff_dec2", dec_mem[2], 8'hF8);

    // Random S, start held through DONE, then a restart on the permuted S.
    load_random();
    model_run();
    do_run(1'b1, cyc);
    n = 0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!finished) bad++;
      if (s_write_enable || dec_write_enable) n++;
    end
    chk("hold_finished_low_cycles", bad, 0);
    chk("hold_spurious_writes", n, 0);
    check_final("hold");
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_release_finished", finished, 0);
    model_run();
    do_run(1'b0, cyc);
    check_final("restart");

    // Fresh random S and ciphertext.
    load_random();
    model_run();
    do_run(1'b0, cyc);
    check_final("rand");

    // Reset during the WR_J cycle of byte 5 (12th S write of the run).
    load_random();
    model_run();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; cyc = 0;
    while (n < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_write_enable) n++;
    end
    chk("abort_found_wrj", n, 12);
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_write_enable || dec_write_enable || finished || (|s_address) ||
          (|s_ram_in) || (|enc_address) || (|dec_address) || (|dec_ram_in))
        bad++;
    end
    chk("abort_quiet_cycles_bad", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rc4_decryptor.md
RC4_DECRYPTOR -- requirements
Module: rc4_decryptor

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of S-box, ciphertext and plaintext bytes.
REQ-002 Parameter ADDR_WIDTH, default 8, S RAM address width; the S RAM holds 2^ADDR_WIDTH entries.
REQ-003 Parameter MSG_LEN, default 32, number of message bytes processed per run.
REQ-004 Parameter MSG_ADDR_WIDTH, default 5, width of the message ROM and RAM addresses.
REQ-005 Port clk input 1, sole clock; all state updates on its rising edge.
REQ-006 Port reset input 1, synchronous, active-high reset.
REQ-007 Port start input 1, level request to begin decryption.
REQ-008 Port finished output 1, high while the run is complete.
REQ-009 Port s_ram_out input DATA_WIDTH, S RAM read data.
REQ-010 Port s_address output ADDR_WIDTH, S RAM address.
REQ-011 Port s_ram_in output DATA_WIDTH, S RAM write data.
REQ-012 Port s_write_enable output 1, S RAM write strobe.
REQ-013 Port enc_rom_out input DATA_WIDTH, ciphertext ROM read data.
REQ-014 Port enc_address output MSG_ADDR_WIDTH, ciphertext ROM address.
REQ-015 Port dec_ram_in output DATA_WIDTH, plaintext RAM write data.
REQ-016 Port dec_address output MSG_ADDR_WIDTH, plaintext RAM address.
REQ-017 Port dec_write_enable output 1, plaintext RAM write strobe.

Function
REQ-018 The block SHALL implement RC4 PRGA: per byte k, i=i+1; j=j+S[i]; swap S[i],S[j]; dec[k]=S[S[i]+S[j]] XOR enc[k].
REQ-019 The block SHALL treat memories as synchronous: an address applied in cycle c is valid on *_out during cycle c+1.
REQ-020 All memory outputs SHALL be combinational from state and internal registers.
REQ-021 The state machine SHALL use states IDLE, RD_I, CAP_I, CAP_J, WR_J, RD_F, CAP_F, DONE.
REQ-022 In IDLE with start high, the block SHALL set i=1, j=0, k=0 and go to RD_I; otherwise it SHALL remain in IDLE.
REQ-023 In RD_I: s_address=i, go to CAP_I.
REQ-024 In CAP_I: capture si=s_ram_out and enc byte=enc_rom_out, set j=j+s_ram_out, drive s_address=j+s_ram_out, go to CAP_J.
REQ-025 In CAP_J: capture sj=s_ram_out; drive s_address=i, s_ram_in=sj, s_write_enable=1; go to WR_J.
REQ-026 In WR_J: drive s_address=j, s_ram_in=si, s_write_enable=1; go to RD_F.
REQ-027 In RD_F: s_address=si+sj (mod 2^ADDR_WIDTH); go to CAP_F.
REQ-028 In CAP_F: dec_address=k, dec_ram_in=s_ram_out XOR enc byte, dec_write_enable=1.
REQ-029 From CAP_F: if k==MSG_LEN-1 go to DONE, else k=k+1, i=i+1, go to RD_I.
REQ-030 enc_address SHALL equal k in every state.
REQ-031 Each byte SHALL take exactly 6 cycles; DONE SHALL be entered on the 6*MSG_LEN-th edge after the edge accepting start.
REQ-032 i, j and address sums SHALL wrap modulo 2^ADDR_WIDTH with no error indication.
REQ-033 When i==j, both swap writes SHALL still occur to the same address, leaving the value unchanged.
REQ-034 In DONE: finished=1; stay while start high; return to IDLE when start low.
REQ-035 A new start SHALL restart at i=1, j=0, k=0 on the current S RAM contents.
REQ-036 Outside the stated cycles, all write enables SHALL be 0 and the output data/addresses SHALL be 0.
REQ-037 start changes outside IDLE/DONE SHALL be ignored.

Reset
REQ-038 On reset: state=IDLE, i=j=k=0, si=sj=0, the enc byte register=0.
REQ-039 On reset: finished=0, both write enables=0, and all addresses and data outputs=0, from the reset edge onward.
REQ-040 Reset mid-run SHALL abort immediately with no further memory writes.

Verification
REQ-041 S[x]=x, enc all 0x00, MSG_LEN=32, start pulse -> dec[0..2]=0x02,0x05,0x07, and S[2]=3, S[3]=5, S[5]=2 after byte 2.
REQ-042 Same S, enc all 0xFF -> dec[0..2]=0xFD,0xFA,0xF8, with finished rising exactly 192 edges after start acceptance.
REQ-043 Byte 0 with identity S (i=j=1) -> two writes of 0x01 to address 1 in consecutive cycles.
REQ-044 Assert reset in the WR_J state of byte 5 -> no write strobes afterward, all outputs 0, and finished stays 0.
REQ-045 Hold start high through DONE -> finished stays 1 with no restart; drop start and re-raise it -> a new run from k=0 with dec[0] matching a software model on the permuted S.
REQ-046 Random S permutation and random enc bytes -> all 32 dec bytes and the final S RAM match a software RC4 PRGA model.
